// File: rtl/alu_writeback_pkg.sv
// Shared types for the ALU writeback buffer: entry struct, depth and field widths.
// The package field widths bound DATA_WIDTH/ADDR_WIDTH of the users.
package alu_writeback_pkg;
  localparam int WB_DEPTH  = 2;
  localparam int WB_DATA_W = 8;
  localparam int WB_ADDR_W = 5;
  localparam int OCC_W     = 2;

  typedef struct packed {
    logic [WB_DATA_W-1:0] aluout;
    logic                 eq;
    logic [WB_ADDR_W-1:0] rd_addr;
    logic                 regwrite;
    logic                 branch;
  } wb_entry_t;
endpackage

// File: rtl/alu_writeback_if.sv
// Upstream ALU handshake plus writeback-side bus of the ALU writeback buffer.
interface alu_writeback_if
  import alu_writeback_pkg::*;
#(
  parameter int DATA_WIDTH = WB_DATA_W,
  parameter int ADDR_WIDTH = WB_ADDR_W
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] aluout;
  logic                  eq;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  regwrite;
  logic                  branch;
  logic                  flush;
  logic                  wb_valid;
  logic                  wb_ready;
  logic [DATA_WIDTH-1:0] wb_data;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic                  wb_en;
  logic                  branch_taken;
  logic [OCC_W-1:0]      occupancy;

  modport master (
    output in_valid, aluout, eq, rd_addr, regwrite, branch, flush, wb_ready,
    input  in_ready, wb_valid, wb_data, wb_addr, wb_en, branch_taken, occupancy
  );

  modport slave (
    input  in_valid, aluout, eq, rd_addr, regwrite, branch, flush, wb_ready,
    output in_ready, wb_valid, wb_data, wb_addr, wb_en, branch_taken, occupancy
  );
endinterface

// File: rtl/alu_wb_fifo.sv
// 2-entry in-order storage with 1-bit wrapping pointers and occupancy count.
// With ALU_WB_FORWARD_EN the slots are exported oldest-first for forwarding.
module alu_wb_fifo
  import alu_writeback_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  wb_entry_t        wr_entry,
  output wb_entry_t        head,
  output logic [OCC_W-1:0] occ
`ifdef ALU_WB_FORWARD_EN
  ,
  output wb_entry_t [WB_DEPTH-1:0] slots
`endif
);
  wb_entry_t [WB_DEPTH-1:0] mem_q, mem_d;
  logic                     wr_ptr_q, wr_ptr_d;
  logic                     rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]         occ_q, occ_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush) begin
      // flush wins over any handshake in the same cycle
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      occ_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wr_entry;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      occ_d = occ_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign head = mem_q[rd_ptr_q];
  assign occ  = occ_q;
`ifdef ALU_WB_FORWARD_EN
  assign slots[0] = mem_q[rd_ptr_q];
  assign slots[1] = mem_q[~rd_ptr_q];
`endif
endmodule

// File: rtl/alu_writeback.sv
// ALU writeback buffer: 2-deep FIFO between ALU and register file / PC logic.
// Optional macro ALU_WB_FORWARD_EN adds a lookup port over buffered results.
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int DATA_WIDTH = WB_DATA_W,
  parameter int ADDR_WIDTH = WB_ADDR_W
)(
  input  logic                  clk,
  input  logic                  rst,
  alu_writeback_if.slave        bus
`ifdef ALU_WB_FORWARD_EN
  ,
  input  logic [ADDR_WIDTH-1:0] fwd_addr,
  output logic                  fwd_hit,
  output logic [DATA_WIDTH-1:0] fwd_data
`endif
);
  wb_entry_t        in_e;
  wb_entry_t        head;
  logic [OCC_W-1:0] occ;
  logic             push, pop;
`ifdef ALU_WB_FORWARD_EN
  wb_entry_t [WB_DEPTH-1:0] slots;
`endif

  always_comb begin
    in_e          = '0;
    in_e.aluout   = WB_DATA_W'(bus.aluout);
    in_e.eq       = bus.eq;
    in_e.rd_addr  = WB_ADDR_W'(bus.rd_addr);
    in_e.regwrite = bus.regwrite;
    in_e.branch   = bus.branch;
  end

  // ready depends only on stored occupancy, never on wb_ready
  assign bus.in_ready = (occ != OCC_W'(WB_DEPTH));
  assign bus.wb_valid = (occ != '0);
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = bus.wb_valid && bus.wb_ready;

  alu_wb_fifo u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .flush    (bus.flush),
    .wr_entry (in_e),
    .head     (head),
    .occ      (occ)
`ifdef ALU_WB_FORWARD_EN
    ,
    .slots    (slots)
`endif
  );

  assign bus.occupancy    = occ;
  assign bus.wb_data      = bus.wb_valid ? DATA_WIDTH'(head.aluout) : '0;
  assign bus.wb_addr      = bus.wb_valid ? ADDR_WIDTH'(head.rd_addr) : '0;
  assign bus.wb_en        = bus.wb_valid && head.regwrite && (head.rd_addr != '0);
  assign bus.branch_taken = bus.wb_valid && head.branch && head.eq;

`ifdef ALU_WB_FORWARD_EN
  // slots are oldest-first, so a later match overrides: youngest wins
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if ((occ > OCC_W'(i)) && slots[i].regwrite && (fwd_addr != '0) &&
          (slots[i].rd_addr == WB_ADDR_W'(fwd_addr))) begin
        fwd_hit  = 1'b1;
        fwd_data = DATA_WIDTH'(slots[i].aluout);
      end
    end
  end
`endif
endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed scenarios then random traffic
// against a queue-based reference model. Honors ALU_WB_FORWARD_EN.
module tb_alu_writeback;
  localparam int DW = 8;
  localparam int AW = 5;

  typedef struct {
    logic [DW-1:0] data;
    logic          eq;
    logic [AW-1:0] rd;
    logic          rw;
    logic          br;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;
  ent_t q[$];

  alu_writeback_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
`ifdef ALU_WB_FORWARD_EN
  logic [AW-1:0] fwd_addr;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
`endif

  alu_writeback #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus)
`ifdef ALU_WB_FORWARD_EN
    ,
    .fwd_addr (fwd_addr),
    .fwd_hit  (fwd_hit),
    .fwd_data (fwd_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [AW-1:0] rd,
                       input logic rw, input logic br, input logic e);
    bus.in_valid = v;
    bus.aluout   = d;
    bus.rd_addr  = rd;
    bus.regwrite = rw;
    bus.branch   = br;
    bus.eq       = e;
  endtask

  // compare every output against the model's current contents
  task automatic check_all();
    bit   ne;
    ent_t h;
    ne = (q.size() != 0);
    h  = ne ? q[0] : '{default: '0};
    chk("occupancy", 32'(bus.occupancy), q.size());
    chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
    chk("wb_valid", 32'(bus.wb_valid), 32'(ne));
    chk("wb_data", 32'(bus.wb_data), ne ? 32'(h.data) : 0);
    chk("wb_addr", 32'(bus.wb_addr), ne ? 32'(h.rd) : 0);
    chk("wb_en", 32'(bus.wb_en), 32'(ne && h.rw && h.rd != 0));
    chk("branch_taken", 32'(bus.branch_taken), 32'(ne && h.br && h.eq));
`ifdef ALU_WB_FORWARD_EN
    begin
      bit            hit = 0;
      logic [DW-1:0] fd  = '0;
      foreach (q[i]) if (q[i].rw && fwd_addr != 0 && q[i].rd == fwd_addr) begin
        hit = 1;
        fd  = q[i].data;
      end
      chk("fwd_hit", 32'(fwd_hit), 32'(hit));
      chk("fwd_data", 32'(fwd_data), 32'(fd));
    end
`endif
  endtask

  // advance model with the inputs currently applied, clock the DUT, then check
  task automatic tick();
    bit   push, pop;
    ent_t e;
    if (rst || bus.flush) q.delete();
    else begin
      push = bus.in_valid && (q.size() < 2);
      pop  = (q.size() != 0) && bus.wb_ready;
      e    = '{data: bus.aluout, eq: bus.eq, rd: bus.rd_addr, rw: bus.regwrite, br: bus.branch};
      if (pop) void'(q.pop_front());
      if (push) q.push_back(e);
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.wb_ready = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
`ifdef ALU_WB_FORWARD_EN
    fwd_addr = '0;
`endif
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_wb_valid", 32'(bus.wb_valid), 0);
    rst = 1'b0;

    // single push, one-cycle latency
    bus.wb_ready = 1'b1;
    drive(1, 8'h2A, 5'd3, 1, 0, 0);
    tick();
    chk("push_wb_valid", 32'(bus.wb_valid), 1);
    chk("push_wb_data", 32'(bus.wb_data), 32'h2A);
    chk("push_wb_addr", 32'(bus.wb_addr), 3);
    chk("push_wb_en", 32'(bus.wb_en), 1);
    drive(0, 0, 0, 0, 0, 0);
    tick();

    // fill, refuse third push, drain in order
    bus.wb_ready = 1'b0;
    drive(1, 8'h11, 5'd1, 1, 0, 0); tick();
    drive(1, 8'h22, 5'd2, 1, 0, 0); tick();
    chk("full_occ", 32'(bus.occupancy), 2);
    chk("full_in_ready", 32'(bus.in_ready), 0);
    drive(1, 8'h33, 5'd3, 1, 0, 0); tick();
    chk("refused_occ", 32'(bus.occupancy), 2);
    chk("hold_head", 32'(bus.wb_data), 32'h11);
    drive(0, 0, 0, 0, 0, 0);
    bus.wb_ready = 1'b1;
    tick();
    chk("drain_second", 32'(bus.wb_data), 32'h22);
    tick();
    chk("drain_empty", 32'(bus.wb_valid), 0);

    // full with push+pop same cycle: push refused
    bus.wb_ready = 1'b0;
    drive(1, 8'h44, 5'd4, 1, 0, 0); tick();
    drive(1, 8'h45, 5'd5, 1, 0, 0); tick();
    bus.wb_ready = 1'b1;
    drive(1, 8'h46, 5'd6, 1, 0, 0); tick();
    chk("full_pop_occ", 32'(bus.occupancy), 1);
    chk("full_pop_head", 32'(bus.wb_data), 32'h45);
    drive(0, 0, 0, 0, 0, 0); tick();

    // x0 writes suppressed
    drive(1, 8'hFF, 5'd0, 1, 0, 0); tick();
    chk("x0_valid", 32'(bus.wb_valid), 1);
    chk("x0_wb_en", 32'(bus.wb_en), 0);

    // branch resolution; occupancy 1 push+pop moves new entry to head
    drive(1, 8'h01, 5'd0, 0, 1, 1); tick();
    chk("br_taken", 32'(bus.branch_taken), 1);
    drive(1, 8'h02, 5'd0, 0, 1, 0); tick();
    chk("br_not_taken", 32'(bus.branch_taken), 0);
    chk("br_occ", 32'(bus.occupancy), 1);
    drive(0, 0, 0, 0, 0, 0); tick();

    // flush while full overrides a simultaneous push
    bus.wb_ready = 1'b0;
    drive(1, 8'h61, 5'd1, 1, 0, 0); tick();
    drive(1, 8'h62, 5'd2, 1, 0, 0); tick();
    bus.flush = 1'b1;
    drive(1, 8'h55, 5'd7, 1, 0, 0); tick();
    chk("flush_occ", 32'(bus.occupancy), 0);
    chk("flush_wb_valid", 32'(bus.wb_valid), 0);
    bus.flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0); tick();
    chk("flush_lost", 32'(bus.wb_valid), 0);

`ifdef ALU_WB_FORWARD_EN
    drive(1, 8'h10, 5'd5, 1, 0, 0); tick();
    drive(1, 8'h20, 5'd5, 1, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    fwd_addr = 5'd5; #1;
    chk("fwd5_hit", 32'(fwd_hit), 1);
    chk("fwd5_data", 32'(fwd_data), 32'h20);
    fwd_addr = 5'd0; #1;
    chk("fwd0_hit", 32'(fwd_hit), 0);
    chk("fwd0_data", 32'(fwd_data), 0);
`endif

    // random traffic
    for (int n = 0; n < 400; n++) begin
      rst          = ($urandom_range(0, 63) == 0);
      bus.flush    = ($urandom_range(0, 15) == 0);
      bus.wb_ready = 1'($urandom_range(0, 1));
      drive(1'($urandom_range(0, 1)), 8'($urandom), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
`ifdef ALU_WB_FORWARD_EN
      fwd_addr = 5'($urandom_range(0, 3));
`endif
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
